adc_scan_ctrl: RTL
==================

// Module: adc_scan_ctrl
// PURPOSE
//  Multi-channel successor to the single-channel ADC req/rdy interface.
//  Scans the enabled ADC channels in ascending order, issuing a req pulse per
//  channel and waiting for rdy with a timeout. Each sample is tagged with its
//  channel and pushed into a FWFT FIFO with a valid/ready output.
//  Sits between the ADC model/pins and downstream sample consumers.
// PARAMETERS
//  DW         8   ADC sample width (bits)
//  NCH        4   number of channels (2..16); CW = $clog2(NCH) (localparam)
//  FIFO_DEPTH 4   sample FIFO entries; must be a power of 2, >=2
//  REQ_PULSE  1   req high time in clk cycles (>=1)
//  TIMEOUT    64  max WAIT cycles for rdy before the channel is skipped (>=2)
// PORTS
//  clk         in   1          system clock, rising edge
//  rst         in   1          async reset, ACTIVE-LOW (0 = reset)
//  start       in   1          1-cycle pulse: begin scan (ignored unless IDLE)
//  stop        in   1          1-cycle pulse: end scan after current channel
//  mode        in   1          0 = single pass, 1 = continuous (sampled at start)
//  chan_mask   in   NCH        channel enables (sampled at start)
//  adc_req     out  1          conversion request to ADC
//  adc_chan    out  CW         channel being converted
//  adc_rdy     in   1          ADC conversion done (level)
//  adc_dat     in   DW         ADC result, valid while adc_rdy=1
//  out_valid   out  1          FIFO head valid (count != 0)
//  out_ready   in   1          consumer accepts head when out_valid&out_ready
//  out_dat     out  DW         FIFO head sample
//  out_chan    out  CW         FIFO head channel tag
//  busy        out  1          1 in any state except IDLE
//  timeout_err out  1          sticky; set on any timeout, cleared by start
//  fifo_count  out  clog2(D)+1 entries held
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; adc_req=0, adc_chan=0, out_valid=0,
//   out_dat=0, out_chan=0, busy=0, timeout_err=0, fifo_count=0;
//   FIFO pointers are cleared. Reset mid-conversion discards everything.
//  FSM: IDLE -> REQ -> WAIT -> STORE -> NEXT -> (REQ | IDLE).
//  IDLE: start with latched mask != 0 -> REQ on the lowest enabled channel.
//   Also clears timeout_err. start with mask == 0 -> stay IDLE; no effect.
//  REQ: adc_req=1 for exactly REQ_PULSE cycles; adc_chan is stable from REQ
//   through STORE. Start edge N -> adc_req high from cycle N+1.
//  WAIT: adc_req=0; cycle counter runs. adc_rdy=1 -> latch adc_dat and chan,
//   go to STORE. Counter reaches TIMEOUT -> set timeout_err, go to NEXT
//   without a FIFO write. adc_rdy is ignored outside WAIT.
//  STORE: push {chan, dat} when count < FIFO_DEPTH, or when a pop occurs in
//   the same cycle; then go to NEXT. Otherwise hold in STORE (backpressure);
//   the sample is never dropped.
//  NEXT: go to the next higher enabled channel. After the highest enabled
//   channel: mode=1 and no stop pending -> wrap to the lowest enabled channel;
//   else -> IDLE.
//  stop: sets a pending flag in any non-IDLE state, cleared on entry to IDLE.
//   The current channel still completes (STORE or timeout).
//  FIFO: FWFT; out_dat/out_chan = head, registered. Push+pop in one cycle
//   leaves count unchanged; pop when empty is ignored. Pointers wrap mod
//   FIFO_DEPTH.
//  Latency: adc_rdy seen in WAIT at edge M -> out_valid=1 at edge M+2,
//   if the FIFO was empty.
// TESTING
//  T1 reset: rst=0 with adc_req/busy high -> all outputs 0 asynchronously,
//   state IDLE.
//  T2 single scan: mask=4'b1011, mode=0, ADC model returns 8'h10+chan after
//   3 cycles -> FIFO gets (0,10),(1,11),(3,13) in order; busy falls;
//   channel 2 is never requested.
//  T3 timeout: mask=4'b0110, ADC never answers ch1 -> timeout_err=1 after 64
//   WAIT cycles; only (2,12) is output.
//  T4 backpressure: mode=1, mask=4'b1111, out_ready=0 -> fifo_count reaches 4,
//   FSM holds in STORE; one pop -> the held sample is written, with no loss
//   or duplicate.
//  T5 stop: continuous scan, stop pulse during WAIT on ch2 -> ch2 stored,
//   then IDLE; ch3 is not requested.
//  T6 edge cases: mask=0 start -> no adc_req; start while busy -> ignored;
//   push+pop at full -> count stays 4.

Source files
------------

// File: rtl/adc_scan_ctrl.sv
// Multi-channel ADC scan controller: walks the enabled channels in ascending order,
// handshakes each conversion (req pulse, rdy with timeout) and queues tagged samples in a FWFT FIFO.
module adc_scan_ctrl #(
    parameter int DW         = 8,
    parameter int NCH        = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int REQ_PULSE  = 1,
    parameter int TIMEOUT    = 64,
    localparam int CW  = $clog2(NCH),
    localparam int AW  = $clog2(FIFO_DEPTH),
    localparam int FCW = AW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           stop,
    input  logic           mode,
    input  logic [NCH-1:0] chan_mask,
    output logic           adc_req,
    output logic [CW-1:0]  adc_chan,
    input  logic           adc_rdy,
    input  logic [DW-1:0]  adc_dat,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_dat,
    output logic [CW-1:0]  out_chan,
    output logic           busy,
    output logic           timeout_err,
    output logic [FCW-1:0] fifo_count
);

    localparam int PW = (REQ_PULSE > 1) ? $clog2(REQ_PULSE) : 1;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [CW-1:0]  chan_q, chan_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic           mode_q, mode_d;
    logic           stop_pend_q, stop_pend_d;
    logic           terr_q, terr_d;
    logic           req_q, req_d;
    logic           busy_q, busy_d;
    logic [PW-1:0]  pcnt_q, pcnt_d;
    logic [TW-1:0]  wcnt_q, wcnt_d;
    logic [DW-1:0]  samp_q, samp_d;

    logic [DW-1:0]  fdat_q  [FIFO_DEPTH];
    logic [CW-1:0]  fchan_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FCW-1:0] count_q, count_d, avail_s;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_dat_q, out_dat_d;
    logic [CW-1:0]  out_chan_q, out_chan_d;
    logic           push_s, pop_s;
    logic [CW:0]    nxt_s;

    function automatic logic [CW-1:0] lowest_ch(input logic [NCH-1:0] m);
        lowest_ch = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i]) lowest_ch = CW'(i);
        end
    endfunction

    // Returns {found, channel} for the lowest enabled channel above cur.
    function automatic logic [CW:0] next_up(input logic [NCH-1:0] m, input logic [CW-1:0] cur);
        next_up = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) next_up = {1'b1, CW'(i)};
        end
    endfunction

    assign pop_s = out_valid_q & out_ready;
    assign nxt_s = next_up(mask_q, chan_q);

    // Scan sequencing: next state, channel selection, handshake counters.
    always_comb begin
        state_d     = state_q;
        chan_d      = chan_q;
        mask_d      = mask_q;
        mode_d      = mode_q;
        stop_pend_d = stop_pend_q;
        terr_d      = terr_q;
        pcnt_d      = pcnt_q;
        wcnt_d      = wcnt_q;
        samp_d      = samp_q;
        push_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (chan_mask != '0)) begin
                    mask_d  = chan_mask;
                    mode_d  = mode;
                    chan_d  = lowest_ch(chan_mask);
                    terr_d  = 1'b0;
                    pcnt_d  = '0;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (pcnt_q == PW'(REQ_PULSE - 1)) begin
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            S_WAIT: begin
                if (adc_rdy) begin
                    samp_d  = adc_dat;
                    state_d = S_STORE;
                end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    terr_d  = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            S_STORE: begin
                // A pop in the same cycle frees a slot even when full.
                if ((count_q < FCW'(FIFO_DEPTH)) || pop_s) begin
                    push_s  = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    state_d = S_STORE;
                end
            end
            S_NEXT: begin
                pcnt_d = '0;
                if (stop_pend_q || stop) begin
                    state_d = S_IDLE;
                end else if (nxt_s[CW]) begin
                    chan_d  = nxt_s[CW-1:0];
                    state_d = S_REQ;
                end else if (mode_q) begin
                    chan_d  = lowest_ch(mask_q);
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_IDLE) begin
            stop_pend_d = 1'b0;
        end else if ((state_q != S_IDLE) && stop) begin
            stop_pend_d = 1'b1;
        end else begin
            stop_pend_d = stop_pend_d;
        end
        req_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
    end

    // FIFO bookkeeping; the head registers track entries already stored, so a
    // new sample becomes visible one cycle after it is written.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(push_s);
        rd_ptr_d    = rd_ptr_q + AW'(pop_s);
        count_d     = count_q + FCW'(push_s) - FCW'(pop_s);
        avail_s     = count_q - FCW'(pop_s);
        out_valid_d = (avail_s != '0);
        out_dat_d   = fdat_q[rd_ptr_d];
        out_chan_d  = fchan_q[rd_ptr_d];
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            chan_q      <= '0;
            mask_q      <= '0;
            mode_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            terr_q      <= 1'b0;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            pcnt_q      <= '0;
            wcnt_q      <= '0;
            samp_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_dat_q   <= '0;
            out_chan_q  <= '0;
        end else begin
            state_q     <= state_d;
            chan_q      <= chan_d;
            mask_q      <= mask_d;
            mode_q      <= mode_d;
            stop_pend_q <= stop_pend_d;
            terr_q      <= terr_d;
            req_q       <= req_d;
            busy_q      <= busy_d;
            pcnt_q      <= pcnt_d;
            wcnt_q      <= wcnt_d;
            samp_q      <= samp_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_dat_q   <= out_dat_d;
            out_chan_q  <= out_chan_d;
        end
    end

    // Sample storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fdat_q[i]  <= '0;
                fchan_q[i] <= '0;
            end
        end else if (push_s) begin
            fdat_q[wr_ptr_q]  <= samp_q;
            fchan_q[wr_ptr_q] <= chan_q;
        end
    end

    assign adc_req     = req_q;
    assign adc_chan    = chan_q;
    assign out_valid   = out_valid_q;
    assign out_dat     = out_dat_q;
    assign out_chan    = out_chan_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    assign fifo_count  = count_q;

endmodule
